// File: rtl/mem_arbiter_pkg.sv
// Shared constants and the per-master request bundle for the two-master memory arbiter.
package mem_arbiter_pkg;

    localparam int NUM_MASTERS        = 2;
    localparam int MASTER_ID_W        = 1;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        wr;
        logic        rd;
    } req_t;

endpackage

// File: rtl/mem_arbiter_id_fifo.sv
// Outstanding-read ID FIFO: single-cycle push/pop, head visible combinationally.
// Push is ignored when full and pop when empty; the caller gates both.
module id_fifo
    import mem_arbiter_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int W     = MASTER_ID_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter of two masters onto one in-order bus; grant and response routing are zero-latency.
// Granted master sees ready only when the bus is ready and, for reads, the ID FIFO has room.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        reset,

    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_write_data,
    input  logic [3:0]  m0_byte_enable,
    input  logic        m0_write_req,
    input  logic        m0_read_req,
    output logic [31:0] m0_read_data,
    output logic        m0_read_data_valid,

    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_write_data,
    input  logic [3:0]  m1_byte_enable,
    input  logic        m1_write_req,
    input  logic        m1_read_req,
    output logic [31:0] m1_read_data,
    output logic        m1_read_data_valid,

    input  logic        bus_ready,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_write_data,
    output logic [3:0]  bus_byte_enable,
    output logic        bus_write_req,
    output logic        bus_read_req,
    input  logic [31:0] bus_read_data,
    input  logic        bus_read_data_valid,

    output logic        orphan_err
);

    req_t                   mreq [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] req;
    logic [MASTER_ID_W-1:0] prio;
    logic [MASTER_ID_W-1:0] gnt_id;
    logic                   gnt_vld;
    req_t                   sel;
    logic                   issue_ok;
    logic                   accept;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [MASTER_ID_W-1:0] head_id;

    always_comb begin
        mreq[0].addr  = m0_addr;
        mreq[0].wdata = m0_write_data;
        mreq[0].be    = m0_byte_enable;
        mreq[0].wr    = m0_write_req;
        mreq[0].rd    = m0_read_req;
        mreq[1].addr  = m1_addr;
        mreq[1].wdata = m1_write_data;
        mreq[1].be    = m1_byte_enable;
        mreq[1].wr    = m1_write_req;
        mreq[1].rd    = m1_read_req;
    end

    assign req = {m1_write_req | m1_read_req, m0_write_req | m0_read_req};

    // With nobody requesting the grant parks on the priority master, whose request bits are then 0.
    always_comb begin
        gnt_vld = |req;
        gnt_id  = prio;
        if (!req[prio] && req[~prio]) begin
            gnt_id = ~prio;
        end
    end

    assign sel      = mreq[gnt_id];
    assign issue_ok = bus_ready && (!sel.rd || !fifo_full);
    assign accept   = gnt_vld && issue_ok;

    assign bus_addr        = sel.addr;
    assign bus_write_data  = sel.wdata;
    assign bus_byte_enable = sel.be;
    assign bus_write_req   = gnt_vld && sel.wr;
    // A full FIFO blocks the read even when a response pops in the same cycle.
    assign bus_read_req    = gnt_vld && sel.rd && !fifo_full;

    assign m0_ready = (gnt_id == 1'b0) && issue_ok;
    assign m1_ready = (gnt_id == 1'b1) && issue_ok;

    assign fifo_push = accept && sel.rd;
    assign fifo_pop  = bus_read_data_valid && !fifo_empty;

    assign m0_read_data       = bus_read_data;
    assign m1_read_data       = bus_read_data;
    assign m0_read_data_valid = fifo_pop && (head_id == 1'b0);
    assign m1_read_data_valid = fifo_pop && (head_id == 1'b1);

    id_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (MASTER_ID_W)
    ) u_id_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (gnt_id),
        .dout  (head_id),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio       <= '0;
            orphan_err <= 1'b0;
        end else begin
            if (accept) begin
                prio <= ~gnt_id;
            end
            if (bus_read_data_valid && fifo_empty) begin
                orphan_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: stimulus queues expected bus transfers and responses; monitors pop and compare.
module tb_mem_arbiter;

    typedef struct {
        logic        id;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        wr;
        logic        rd;
    } bus_exp_t;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } rsp_exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_addr, m1_addr, m0_write_data, m1_write_data;
    logic [3:0]  m0_byte_enable, m1_byte_enable;
    logic        m0_write_req, m0_read_req, m1_write_req, m1_read_req;
    logic [31:0] m0_read_data, m1_read_data;
    logic        m0_read_data_valid, m1_read_data_valid;
    logic        bus_ready;
    logic [31:0] bus_addr, bus_write_data, bus_read_data;
    logic [3:0]  bus_byte_enable;
    logic        bus_write_req, bus_read_req, bus_read_data_valid;
    logic        orphan_err;

    int checks = 0;
    int errors = 0;
    bus_exp_t exp_bus[$];
    rsp_exp_t exp_rsp[$];

    mem_arbiter #(.FIFO_DEPTH(4)) dut (
        .clk                 (clk),
        .reset               (reset),
        .m0_ready            (m0_ready),
        .m0_addr             (m0_addr),
        .m0_write_data       (m0_write_data),
        .m0_byte_enable      (m0_byte_enable),
        .m0_write_req        (m0_write_req),
        .m0_read_req         (m0_read_req),
        .m0_read_data        (m0_read_data),
        .m0_read_data_valid  (m0_read_data_valid),
        .m1_ready            (m1_ready),
        .m1_addr             (m1_addr),
        .m1_write_data       (m1_write_data),
        .m1_byte_enable      (m1_byte_enable),
        .m1_write_req        (m1_write_req),
        .m1_read_req         (m1_read_req),
        .m1_read_data        (m1_read_data),
        .m1_read_data_valid  (m1_read_data_valid),
        .bus_ready           (bus_ready),
        .bus_addr            (bus_addr),
        .bus_write_data      (bus_write_data),
        .bus_byte_enable     (bus_byte_enable),
        .bus_write_req       (bus_write_req),
        .bus_read_req        (bus_read_req),
        .bus_read_data       (bus_read_data),
        .bus_read_data_valid (bus_read_data_valid),
        .orphan_err          (orphan_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic exp_read(input logic id, input logic [31:0] addr);
        bus_exp_t e;
        e.id = id; e.addr = addr; e.wdata = 32'h0; e.be = 4'h0; e.wr = 1'b0; e.rd = 1'b1;
        exp_bus.push_back(e);
    endtask

    task automatic exp_write(input logic id, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
        bus_exp_t e;
        e.id = id; e.addr = addr; e.wdata = wd; e.be = be; e.wr = 1'b1; e.rd = 1'b0;
        exp_bus.push_back(e);
    endtask

    // One response cycle on the bus; port is where it must land, or none for an orphan.
    task automatic respond(input logic [31:0] data, input logic port, input logic expect_route);
        rsp_exp_t r;
        if (expect_route) begin
            r.port = port; r.data = data;
            exp_rsp.push_back(r);
        end
        bus_read_data_valid = 1'b1;
        bus_read_data       = data;
        @(posedge clk); #1;
        bus_read_data_valid = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    // Bus-side monitor: every accepted transfer must match the next expected one.
    always @(negedge clk) begin
        if (!reset && bus_ready && (bus_read_req || bus_write_req)) begin
            if (exp_bus.size() == 0) begin
                checks++; errors++;
                $display("FAIL bus_unexpected: got addr %0h wr %0b rd %0b required no transfer",
                         bus_addr, bus_write_req, bus_read_req);
            end else begin
                bus_exp_t e;
                e = exp_bus.pop_front();
                check("bus_xfer", {m1_ready, m0_ready, bus_addr, bus_write_data, bus_byte_enable, bus_write_req, bus_read_req},
                      {e.id, ~e.id, e.addr, e.wdata, e.be, e.wr, e.rd});
            end
        end
    end

    // Response monitor: each routed valid must hit the expected port with the expected data.
    always @(negedge clk) begin
        if (!reset && (m0_read_data_valid || m1_read_data_valid)) begin
            if (exp_rsp.size() == 0) begin
                checks++; errors++;
                $display("FAIL rsp_unexpected: got valids m1/m0 %0b%0b required none",
                         m1_read_data_valid, m0_read_data_valid);
            end else begin
                rsp_exp_t r;
                r = exp_rsp.pop_front();
                check("rsp_port", {m1_read_data_valid, m0_read_data_valid}, r.port ? 2'b10 : 2'b01);
                check("rsp_data_m0", m0_read_data, r.data);
                check("rsp_data_m1", m1_read_data, r.data);
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus_ready = 1'b1; bus_read_data = '0; bus_read_data_valid = 1'b0;
        m0_addr = '0; m0_write_data = '0; m0_byte_enable = '0; m0_write_req = 1'b0; m0_read_req = 1'b1;
        m1_addr = '0; m1_write_data = '0; m1_byte_enable = '0; m1_write_req = 1'b0; m1_read_req = 1'b0;

        // Reset state; a pending m0 read sees ready since the FIFO is empty.
        repeat (2) @(negedge clk);
        check("reset_valids", {m1_read_data_valid, m0_read_data_valid}, 2'b00);
        check("reset_orphan", orphan_err, 1'b0);
        check("reset_ready", {m1_ready, m0_ready}, 2'b01);
        m0_read_req = 1'b0;
        @(negedge clk);
        check("reset_idle_bus", {bus_write_req, bus_read_req}, 2'b00);
        next_cycle();
        reset = 1'b0;

        // Contention: both read continuously, grants alternate m0, m1, m0, m1.
        m0_addr = 32'h100; m1_addr = 32'h200;
        m0_read_req = 1'b1; m1_read_req = 1'b1;
        exp_read(0, 32'h100); exp_read(1, 32'h200); exp_read(0, 32'h100); exp_read(1, 32'h200);
        repeat (4) next_cycle();
        m0_read_req = 1'b0; m1_read_req = 1'b0;
        for (int i = 0; i < 4; i++) respond(32'hD000_0000 + i, i[0], 1'b1);

        // FIFO full: four m0 reads fill it, the fifth stalls.
        m0_addr = 32'h300; m0_read_req = 1'b1;
        repeat (4) exp_read(0, 32'h300);
        repeat (4) next_cycle();
        m0_addr = 32'h304;
        @(negedge clk);
        check("full_m0_ready", m0_ready, 1'b0);
        check("full_bus_read_req", bus_read_req, 1'b0);

        // Write pass-through while full; m1 holds priority after m0's accepts.
        next_cycle();
        m1_addr = 32'h2000_0000; m1_write_data = 32'hDEAD_BEEF; m1_byte_enable = 4'hF; m1_write_req = 1'b1;
        exp_write(1, 32'h2000_0000, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk);
        check("wr_m1_ready", {m1_ready, m0_ready}, 2'b10);
        check("wr_bus_fields", {bus_write_req, bus_read_req, bus_addr, bus_write_data, bus_byte_enable},
              {1'b1, 1'b0, 32'h2000_0000, 32'hDEAD_BEEF, 4'hF});
        next_cycle();
        m1_write_req = 1'b0; m1_write_data = '0; m1_byte_enable = '0;

        // A pop in the same cycle does not unblock the read.
        bus_read_data_valid = 1'b1; bus_read_data = 32'hE0;
        begin
            rsp_exp_t r;
            r.port = 1'b0; r.data = 32'hE0;
            exp_rsp.push_back(r);
        end
        @(negedge clk);
        check("pop_same_cycle_ready", m0_ready, 1'b0);
        check("pop_same_cycle_req", bus_read_req, 1'b0);
        next_cycle();
        bus_read_data_valid = 1'b0;
        exp_read(0, 32'h304);
        @(negedge clk);
        check("after_pop_accept", m0_ready, 1'b1);
        next_cycle();
        // Full again only if the write pushed nothing.
        m0_addr = 32'h308;
        @(negedge clk);
        check("refull_ready", m0_ready, 1'b0);
        next_cycle();
        m0_read_req = 1'b0;
        for (int i = 1; i <= 4; i++) respond(32'hE0 + i, 1'b0, 1'b1);

        // Backpressure: m1 write first moves priority to m0.
        m1_addr = 32'h500; m1_write_data = 32'h1234; m1_byte_enable = 4'h3; m1_write_req = 1'b1;
        exp_write(1, 32'h500, 32'h1234, 4'h3);
        next_cycle();
        m1_write_req = 1'b0; m1_write_data = '0; m1_byte_enable = '0;
        bus_ready = 1'b0;
        m0_addr = 32'h400; m0_read_req = 1'b1;
        m1_addr = 32'h404; m1_read_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_ready", {m1_ready, m0_ready}, 2'b00);
            check("bp_bus", {bus_read_req, bus_addr}, {1'b1, 32'h400});
            next_cycle();
        end
        bus_ready = 1'b1;
        exp_read(0, 32'h400);
        @(negedge clk);
        check("bp_release_m0", {m1_ready, m0_ready}, 2'b01);
        next_cycle();
        m0_read_req = 1'b0;
        exp_read(1, 32'h404);
        @(negedge clk);
        check("bp_then_m1", {m1_ready, m0_ready}, 2'b10);
        next_cycle();
        m1_read_req = 1'b0;
        respond(32'hB0, 1'b0, 1'b1);
        respond(32'hB1, 1'b1, 1'b1);

        // Orphan response with the FIFO empty.
        bus_read_data_valid = 1'b1; bus_read_data = 32'hFF;
        @(negedge clk);
        check("orphan_valids", {m1_read_data_valid, m0_read_data_valid}, 2'b00);
        next_cycle();
        bus_read_data_valid = 1'b0;
        @(negedge clk);
        check("orphan_set", orphan_err, 1'b1);
        repeat (3) next_cycle();
        @(negedge clk);
        check("orphan_sticky", orphan_err, 1'b1);

        // Reset with two reads outstanding; last accept leaves prio at m1.
        next_cycle();
        m0_addr = 32'h600; m0_read_req = 1'b1;
        exp_read(0, 32'h600); exp_read(0, 32'h600);
        repeat (2) next_cycle();
        m0_read_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("rst_orphan_clear", orphan_err, 1'b0);
        check("rst_valids", {m1_read_data_valid, m0_read_data_valid}, 2'b00);
        next_cycle();
        reset = 1'b0;
        bus_read_data_valid = 1'b1; bus_read_data = 32'hAA;
        @(negedge clk);
        check("post_rst_dropped", {m1_read_data_valid, m0_read_data_valid}, 2'b00);
        next_cycle();
        bus_read_data_valid = 1'b0;
        @(negedge clk);
        check("post_rst_orphan", orphan_err, 1'b1);
        next_cycle();
        m0_addr = 32'h700; m0_read_req = 1'b1;
        m1_addr = 32'h704; m1_read_req = 1'b1;
        exp_read(0, 32'h700);
        @(negedge clk);
        check("post_rst_prio", {m1_ready, m0_ready}, 2'b01);
        next_cycle();
        m0_read_req = 1'b0; m1_read_req = 1'b0;
        respond(32'hC0, 1'b0, 1'b1);

        repeat (2) next_cycle();
        check("bus_queue_drained", exp_bus.size(), 0);
        check("rsp_queue_drained", exp_rsp.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the maximum number of outstanding reads tracked; power of two, at least 2.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have, for each master port mN (N=0 instruction fetch, N=1 data), these signals:
- mN_ready, output, 1 bit
- mN_addr, input, 32 bits
- mN_write_data, input, 32 bits
- mN_byte_enable, input, 4 bits
- mN_write_req, input, 1 bit
- mN_read_req, input, 1 bit
- mN_read_data, output, 32 bits
- mN_read_data_valid, output, 1 bit
REQ-005 SHALL have a downstream bus port with these signals:
- bus_ready, input, 1 bit
- bus_addr, output, 32 bits
- bus_write_data, output, 32 bits
- bus_byte_enable, output, 4 bits
- bus_write_req, output, 1 bit
- bus_read_req, output, 1 bit
- bus_read_data, input, 32 bits
- bus_read_data_valid, input, 1 bit
REQ-006 SHALL have port orphan_err, output, 1 bit: sticky flag set when a response arrives with no outstanding read.

Function
REQ-007 SHALL treat a master as requesting when mN_write_req or mN_read_req is high; a master never asserts both in the same cycle.
REQ-008 SHALL select exactly one requesting master per cycle, combinationally, using round-robin priority held in a 1-bit pointer prio.
- prio = 0 gives m0 priority.
- The non-priority master is granted only when the priority master is idle.
REQ-009 SHALL drive bus_addr, bus_write_data, bus_byte_enable and the bus_*_req signals from the granted master with zero added latency; with no grant, all bus_*_req are 0.
REQ-010 SHALL define issue_ok as: bus_ready is 1, and either the request is a write or the ID FIFO is not full.
REQ-011 SHALL suppress bus_read_req when the granted request is a read and the FIFO is full.
- A full FIFO blocks a read even if a pop occurs in the same cycle.
REQ-012 SHALL drive the granted master's mN_ready = issue_ok, and drive the other master's mN_ready = 0.
REQ-013 SHALL consider a request accepted in any cycle where it is granted and issue_ok is 1.
- On acceptance, prio is set to the index of the non-accepted master.
- Otherwise prio holds.
REQ-014 SHALL push the granted master's index into the ID FIFO on each accepted read; writes push nothing.
REQ-015 SHALL route bus_read_data_valid to mN_read_data_valid combinationally, where N is the ID at the FIFO head, and pop the FIFO in that cycle.
REQ-016 SHALL drive mN_read_data = bus_read_data on both ports at all times; only the valid signals differ.
REQ-017 SHALL handle a push and a pop in the same cycle with the FIFO neither full nor empty by updating both pointers, leaving the count unchanged.
REQ-018 SHALL, when bus_read_data_valid arrives with the FIFO empty, assert no mN_read_data_valid and set orphan_err to 1 until reset.
REQ-019 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH.
- Count width is $clog2(FIFO_DEPTH)+1.
- full is defined as count == FIFO_DEPTH; empty as count == 0.
REQ-020 SHALL return responses in the order reads were issued, relying on the downstream in-order guarantee.

Reset
REQ-021 SHALL, while reset is asserted, force: FIFO empty, both pointers 0, prio = 0, orphan_err = 0.
REQ-022 SHALL drop in-flight read IDs on reset mid-operation; responses arriving after reset deasserts with the FIFO empty follow REQ-018.
REQ-023 SHALL keep combinational outputs derived from reset state during reset: mN_read_data_valid = 0, and mN_ready per REQ-012 with an empty FIFO.

Structure
REQ-024 SHALL place NUM_MASTERS = 2, master-ID width MASTER_ID_W = 1, and DEFAULT_FIFO_DEPTH = 4 in shared package mem_arbiter_pkg.
REQ-025 SHALL implement the ID FIFO as one sub-module, id_fifo, with push, pop, din, dout, full and empty ports; all arbitration logic stays in mem_arbiter.

Verification
REQ-026 SHALL cover contention: both masters issue continuous reads, bus_ready = 1, prio = 0.
- Expected bus grants: m0, m1, m0, m1.
- Expected responses routed in the same order to the matching port.
REQ-027 SHALL cover FIFO-full stall: m0 issues 4 reads with no responses returned.
- The 5th read sees m0_ready = 0 and bus_read_req = 0.
- After one response, the 5th read is accepted on the following cycle.
REQ-028 SHALL cover write pass-through: m1 writes addr 0x2000_0000, data 0xDEAD_BEEF, byte_enable 0xF.
- Same cycle: bus_write_req = 1 with identical fields, m1_ready = 1.
- FIFO count is unchanged.
REQ-029 SHALL cover backpressure: bus_ready = 0 for 3 cycles while m0 reads.
- m0_ready = 0 for 3 cycles.
- prio is unchanged throughout.
- The read is accepted on the cycle bus_ready rises.
REQ-030 SHALL cover orphan response: bus_read_data_valid = 1 with the FIFO empty.
- Both valid outputs stay 0 and orphan_err = 1.
- orphan_err returns to 0 only when reset is asserted.
REQ-031 SHALL cover reset mid-operation: reset asserted with 2 reads outstanding.
- After reset: FIFO empty, prio = 0, m0_ready follows REQ-012.
